// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: start/done handshake and operand/result bus for the serial subtractor
// master drives start, a, b, bin; slave returns busy, done, diff and the flags bout/zero/neg/ovf
interface nibble_serial_subtractor_if #(parameter int WIDTH = 16);
  logic start, bin, busy, done, bout, zero, neg, ovf;
  logic [WIDTH-1:0] a, b, diff;
  modport master(output start, a, b, bin, input busy, done, diff, bout, zero, neg, ovf);
  modport slave(input start, a, b, bin, output busy, done, diff, bout, zero, neg, ovf);
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: a - b - bin computed one 4-bit lookahead nibble per clock, LSB first
// ports: clk, rst_n (async active-low), bus (slave): start/a/b/bin in, busy/done/diff/bout/zero/neg/ovf out
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_subtractor_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] opa, opb, part, diff_r, part_nx;
  logic [CW-1:0] cnt;
  logic c, busy_r, done_r, bout_r, zero_r, neg_r, ovf_r;
  logic [3:0] p, g, sum;
  logic c1, c2, c3, co, last, accept, ovf_nx;
  assign p = opa[3:0] ^ opb[3:0];
  assign g = opa[3:0] & opb[3:0];
  assign c1 = g[0] | (p[0] & c);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c);
  assign sum = p ^ {c3, c2, c1, c};
  // sum nibble enters from the MSB side so the LSB nibble ends up at the bottom after NIBBLES shifts
  assign part_nx = WIDTH'({sum, part} >> 4);
  assign last = cnt == CW'(NIBBLES - 1);
  assign accept = bus.start && state != RUN;
  // on the last nibble c3 is the carry into the sign bit
  assign ovf_nx = c3 ^ co;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.zero = zero_r;
  assign bus.neg = neg_r;
  assign bus.ovf = ovf_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      opa <= '0;
      opb <= '0;
      part <= '0;
      cnt <= '0;
      c <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      busy_r <= 1'b1;
      done_r <= 1'b0;
      opa <= bus.a;
      opb <= ~bus.b;
      c <= ~bus.bin;
      cnt <= '0;
      part <= '0;
    end else if (state == RUN) begin
      opa <= opa >> 4;
      opb <= opb >> 4;
      part <= part_nx;
      c <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
        diff_r <= part_nx;
        bout_r <= ~co;
        ovf_r <= ovf_nx;
        neg_r <= part_nx[WIDTH-1] ^ ovf_nx;
        zero_r <= part_nx == '0;
      end
    end else begin
      state <= IDLE;
      done_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: scoreboard bench for 4/8/16-bit instances of the serial subtractor
module tb_nibble_serial_subtractor;
  typedef struct packed {
    logic [15:0] diff;
    logic bout, zero, neg, ovf;
  } res_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [15:0] ra[3], rb[3], dv[3];
  logic rbin[3], rs[3], dn[3], bz[3], bo[3], ze[3], ne[3], ov[3];
  res_t sbq[3][$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nibble_serial_subtractor_if #(4) b4();
  nibble_serial_subtractor_if #(8) b8();
  nibble_serial_subtractor_if #(16) b16();
  assign b4.start = rs[0];
  assign b4.a = ra[0][3:0];
  assign b4.b = rb[0][3:0];
  assign b4.bin = rbin[0];
  assign b8.start = rs[1];
  assign b8.a = ra[1][7:0];
  assign b8.b = rb[1][7:0];
  assign b8.bin = rbin[1];
  assign b16.start = rs[2];
  assign b16.a = ra[2];
  assign b16.b = rb[2];
  assign b16.bin = rbin[2];
  assign dv[0] = {12'h0, b4.diff};
  assign dv[1] = {8'h0, b8.diff};
  assign dv[2] = b16.diff;
  assign dn = '{b4.done, b8.done, b16.done};
  assign bz = '{b4.busy, b8.busy, b16.busy};
  assign bo = '{b4.bout, b8.bout, b16.bout};
  assign ze = '{b4.zero, b8.zero, b16.zero};
  assign ne = '{b4.neg, b8.neg, b16.neg};
  assign ov = '{b4.ovf, b8.ovf, b16.ovf};
  nibble_serial_subtractor #(.WIDTH(4)) d4(.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  nibble_serial_subtractor #(.WIDTH(8)) d8(.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  nibble_serial_subtractor #(.WIDTH(16)) d16(.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  function automatic res_t obs(int k);
    return {dv[k], bo[k], ze[k], ne[k], ov[k]};
  endfunction

  function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic bin);
    res_t r;
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    r.diff = (a - b - 16'(bin)) & mask;
    r.bout = int'(a) < int'(b) + int'(bin);
    r.ovf = (a[w-1] != b[w-1]) && (r.diff[w-1] != a[w-1]);
    r.neg = r.diff[w-1] ^ r.ovf;
    r.zero = r.diff == 16'h0;
    return r;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bz[k] && dn[k]) begin
        errors++;
        $display("FAIL busy_done_overlap inst=%0d busy=%b done=%b required not both 1", k, bz[k], dn[k]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic op16(input string name, input logic [15:0] a, input logic [15:0] b, input logic bin, input res_t exp);
    int cyc;
    res_t o, e;
    @(negedge clk);
    ra[2] = a; rb[2] = b; rbin[2] = bin; rs[2] = 1'b1;
    sbq[2].push_back(exp);
    @(negedge clk);
    rs[2] = 1'b0;
    checks++;
    if (bz[2] !== 1'b1) begin errors++; $display("FAIL %s_busy got %b need 1", name, bz[2]); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dn[2] && cyc < 20);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL %s_latency got %0d need 4", name, cyc); end
    o = obs(2);
    e = sbq[2].pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL %s_result got %h need %h (diff,bout,zero,neg,ovf)", name, o, e); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin ra[k] = '0; rb[k] = '0; rbin[k] = 1'b0; rs[k] = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bz[k], dn[k], obs(k)} !== 22'h0) begin
        errors++;
        $display("FAIL reset inst=%0d got busy=%b done=%b res=%h need all 0", k, bz[k], dn[k], obs(k));
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    op16("basic", 16'h1234, 16'h0034, 1'b0, {16'h1200, 1'b0, 1'b0, 1'b0, 1'b0});
    op16("borrow", 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    op16("overflow", 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1});
    op16("zero_bin", 16'h5555, 16'h5554, 1'b1, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic test_ignore_start();
    int cyc, extra;
    @(negedge clk);
    ra[2] = 16'h1234; rb[2] = 16'h0034; rbin[2] = 1'b0; rs[2] = 1'b1;
    sbq[2].push_back({16'h1200, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rs[2] = 1'b0;
    @(negedge clk);
    ra[2] = 16'hFFFF; rb[2] = 16'h0000; rs[2] = 1'b1;
    @(negedge clk);
    rs[2] = 1'b0;
    cyc = 2;
    while (!dn[2] && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL ignore_latency got %0d need 4", cyc); end
    checks++;
    if (obs(2) !== sbq[2][0]) begin errors++; $display("FAIL ignore_result got %h need %h", obs(2), sbq[2][0]); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (dn[2]) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ignore_extra_done got %0d need 0", extra); end
    checks++;
    if (dv[2] !== sbq[2][0].diff) begin errors++; $display("FAIL ignore_hold got %h need %h", dv[2], sbq[2][0].diff); end
    void'(sbq[2].pop_front());
  endtask

  task automatic test_back_to_back();
    int cyc;
    res_t e;
    @(negedge clk);
    ra[2] = 16'h1234; rb[2] = 16'h0034; rbin[2] = 1'b0; rs[2] = 1'b1;
    sbq[2].push_back({16'h1200, 1'b0, 1'b0, 1'b0, 1'b0});
    sbq[2].push_back({16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    ra[2] = 16'h0000; rb[2] = 16'h0001;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dn[2] && cyc < 20);
    e = sbq[2].pop_front();
    checks++;
    if (cyc != 4 || obs(2) !== e) begin errors++; $display("FAIL b2b_first got cyc=%0d res=%h need cyc=4 res=%h", cyc, obs(2), e); end
    @(negedge clk);
    rs[2] = 1'b0;
    cyc = 1;
    checks++;
    if (bz[2] !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b need 1", bz[2]); end
    while (!dn[2] && cyc < 20) begin @(negedge clk); cyc++; end
    e = sbq[2].pop_front();
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL b2b_spacing got %0d need 5", cyc); end
    checks++;
    if (obs(2) !== e) begin errors++; $display("FAIL b2b_second got %h need %h", obs(2), e); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    ra[2] = 16'h00FF; rb[2] = 16'h0001; rbin[2] = 1'b0; rs[2] = 1'b1;
    @(negedge clk);
    rs[2] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bz[2], dn[2], obs(2)} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b res=%h need all 0", bz[2], dn[2], obs(2));
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (dn[2]) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_done got %0d pulses need 0", seen); end
    op16("after_reset", 16'h00FF, 16'h0001, 1'b0, {16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_random();
    logic [15:0] held[3];
    logic got[3];
    res_t e;
    int cyc;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) held[k] = 16'h0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        ra[k] = 16'($urandom) & 16'((32'd1 << (4 << k)) - 1);
        rb[k] = 16'($urandom) & 16'((32'd1 << (4 << k)) - 1);
        rbin[k] = 1'($urandom);
        rs[k] = 1'b1;
        got[k] = 1'b0;
        sbq[k].push_back(model(4 << k, ra[k], rb[k], rbin[k]));
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        rs[k] = 1'b0;
        checks++;
        if (dv[k] !== held[k]) begin errors++; $display("FAIL rand_hold w=%0d got %h need %h", 4 << k, dv[k], held[k]); end
      end
      cyc = 0;
      while (!(got[0] && got[1] && got[2]) && cyc < 10) begin
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (dn[k]) begin
            if (sbq[k].size() == 0) begin
              errors++;
              $display("FAIL rand_spurious_done w=%0d", 4 << k);
            end else begin
              e = sbq[k].pop_front();
              held[k] = e.diff;
              got[k] = 1'b1;
              if (obs(k) !== e) begin errors++; $display("FAIL rand_result w=%0d i=%0d got %h need %h", 4 << k, i, obs(k), e); end
            end
          end else if (dv[k] !== held[k]) begin
            errors++;
            $display("FAIL rand_hold w=%0d got %h need %h", 4 << k, dv[k], held[k]);
          end
        end
      end
      checks++;
      if (!(got[0] && got[1] && got[2])) begin
        errors++;
        $display("FAIL rand_timeout i=%0d got done %b%b%b need 111", i, got[0], got[1], got[2]);
        for (int k = 0; k < 3; k++) sbq[k].delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
